// File: rtl/i8080_rx_fifo_writer.sv
// i8080_rx_fifo_writer: i8080 16-bit write-bus slave that decodes DCS commands and
// pushes RGB565 pixels into the pixel FIFO for the RGB timing generator.
module i8080_rx_fifo_writer #(
    parameter int          WidthPixel  = 800,
    parameter int          HightPixel  = 480,
    parameter logic [7:0]  CMD_RAMWR   = 8'h2C,
    parameter logic [7:0]  CMD_RAMWRC  = 8'h3C,
    parameter logic [7:0]  CMD_SWRESET = 8'h01
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        I80_CS,
    input  logic        I80_RS,
    input  logic        I80_WR,
    input  logic [15:0] I80_D,
    input  logic        FIFO_Full,
    output logic        FIFO_WE,
    output logic [15:0] FIFO_WData,
    output logic        FrameCtrl,
    output logic        FrameDone,
    output logic        Overflow
);
    localparam logic [18:0] Total = 19'(WidthPixel * HightPixel);

    typedef enum logic {IDLE, PIXEL} state_t;

    state_t      state, state_n;
    logic [18:0] pix_cnt, pix_cnt_n;
    logic        overflow_n, we_n, done_n;
    logic [15:0] wdata_n;
    logic [1:0]  cs_q, rs_q;
    logic [2:0]  wr_q;
    logic [15:0] d_q1, d_q2;
    logic        wr_rise;

    // Synchronisers preset to the idle bus level; wr_q[2] is the edge-detect history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cs_q <= '1;
            rs_q <= '1;
            wr_q <= '1;
            d_q1 <= '1;
            d_q2 <= '1;
        end else begin
            cs_q <= {cs_q[0], I80_CS};
            rs_q <= {rs_q[0], I80_RS};
            wr_q <= {wr_q[1:0], I80_WR};
            d_q1 <= I80_D;
            d_q2 <= d_q1;
        end
    end

    assign wr_rise = wr_q[1] & ~wr_q[2] & ~cs_q[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            Overflow   <= 1'b0;
            FIFO_WE    <= 1'b0;
            FrameDone  <= 1'b0;
            FIFO_WData <= '0;
        end else begin
            state      <= state_n;
            pix_cnt    <= pix_cnt_n;
            Overflow   <= overflow_n;
            FIFO_WE    <= we_n;
            FrameDone  <= done_n;
            FIFO_WData <= wdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        pix_cnt_n  = pix_cnt;
        overflow_n = Overflow;
        we_n       = 1'b0;
        done_n     = 1'b0;
        wdata_n    = FIFO_WData;
        if (wr_rise && !rs_q[1]) begin
            if (d_q2[7:0] == CMD_SWRESET) begin
                state_n    = IDLE;
                pix_cnt_n  = '0;
                overflow_n = 1'b0;
            end else if (d_q2[7:0] == CMD_RAMWR) begin
                state_n    = PIXEL;
                pix_cnt_n  = '0;
                overflow_n = 1'b0;
            end else if (state == IDLE) begin
                state_n = (d_q2[7:0] == CMD_RAMWRC && pix_cnt < Total) ? PIXEL : IDLE;
            end else begin
                state_n = IDLE;
            end
        end else if (wr_rise && state == PIXEL) begin
            // A dropped word still consumes its pixel slot so the frame stays aligned
            wdata_n    = d_q2;
            we_n       = ~FIFO_Full;
            overflow_n = Overflow | FIFO_Full;
            pix_cnt_n  = pix_cnt + 19'd1;
            done_n     = (pix_cnt_n == Total);
            state_n    = done_n ? IDLE : PIXEL;
        end
    end

    always_comb begin
        FrameCtrl = (state == PIXEL);
    end
endmodule

// File: tb/tb_i8080_rx_fifo_writer.sv
// tb_i8080_rx_fifo_writer: directed scenarios for the i8080 receiver with an 8-pixel
// frame (4x2), checking FIFO pushes, frame control, overflow and reset behaviour.
module tb_i8080_rx_fifo_writer;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        I80_CS = 1'b1;
    logic        I80_RS = 1'b1;
    logic        I80_WR = 1'b1;
    logic [15:0] I80_D = 16'h0000;
    logic        FIFO_Full = 1'b0;
    logic        FIFO_WE;
    logic [15:0] FIFO_WData;
    logic        FrameCtrl;
    logic        FrameDone;
    logic        Overflow;

    int          total = 0;
    int          passed = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          lone_done = 0;
    logic [15:0] words[$];

    i8080_rx_fifo_writer #(.WidthPixel(4), .HightPixel(2)) dut (
        .CLK(CLK), .nRST(nRST), .I80_CS(I80_CS), .I80_RS(I80_RS), .I80_WR(I80_WR),
        .I80_D(I80_D), .FIFO_Full(FIFO_Full), .FIFO_WE(FIFO_WE), .FIFO_WData(FIFO_WData),
        .FrameCtrl(FrameCtrl), .FrameDone(FrameDone), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FIFO_WE) begin
            we_cnt++;
            words.push_back(FIFO_WData);
        end
        if (FrameDone) done_cnt++;
        if (FrameDone && !FIFO_WE) lone_done++;
    end

    task automatic clear_mon();
        we_cnt = 0;
        done_cnt = 0;
        lone_done = 0;
        words.delete();
    endtask

    task automatic bus_wr(input logic cs, input logic rs, input logic [15:0] d);
        @(posedge CLK);
        #3;
        I80_CS = cs;
        I80_RS = rs;
        I80_D  = d;
        I80_WR = 1'b0;
        repeat (4) @(posedge CLK);
        #3 I80_WR = 1'b1;
        repeat (4) @(posedge CLK);
        #3 I80_CS = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #2;
        total++; if (FIFO_WE !== 1'b0) $display("FAIL reset_we: got %b expected 0", FIFO_WE); else passed++;
        total++; if (FIFO_WData !== 16'h0) $display("FAIL reset_wdata: got %h expected 0000", FIFO_WData); else passed++;
        total++; if ({FrameCtrl, FrameDone, Overflow} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {FrameCtrl, FrameDone, Overflow}); else passed++;
        total++; if (dut.pix_cnt !== 19'd0) $display("FAIL reset_pixcnt: got %0d expected 0", dut.pix_cnt); else passed++;
        nRST = 1'b1;
    endtask

    task automatic test_full_frame();
        clear_mon();
        bus_wr(1'b0, 1'b0, 16'h002C);
        total++; if (FrameCtrl !== 1'b1) $display("FAIL frame_ctrl_on: got %b expected 1", FrameCtrl); else passed++;
        for (int i = 0; i < 8; i++) begin
            bus_wr(1'b0, 1'b1, 16'hA000 + 16'(i * 16'h0111));
            if (i == 6) begin
                total++; if (FrameCtrl !== 1'b1) $display("FAIL frame_ctrl_held: got %b expected 1", FrameCtrl); else passed++;
            end
        end
        total++; if (we_cnt !== 8) $display("FAIL frame_we_count: got %0d expected 8", we_cnt); else passed++;
        total++;
        if (words.size() != 8) $display("FAIL frame_words_size: got %0d expected 8", words.size());
        else passed++;
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== 16'hA000 + 16'(i * 16'h0111)) $display("FAIL frame_word%0d: got %h expected %h", i, words[i], 16'hA000 + 16'(i * 16'h0111));
            else passed++;
        end
        total++; if (done_cnt !== 1 || lone_done !== 0) $display("FAIL frame_done: got %0d pulses (%0d without WE) expected 1 (0)", done_cnt, lone_done); else passed++;
        total++; if (FrameCtrl !== 1'b0) $display("FAIL frame_ctrl_off: got %b expected 0", FrameCtrl); else passed++;
        total++; if (dut.pix_cnt !== 19'd8) $display("FAIL frame_pixcnt: got %0d expected 8", dut.pix_cnt); else passed++;
        bus_wr(1'b0, 1'b0, 16'h003C);
        total++; if (FrameCtrl !== 1'b0) $display("FAIL ramwrc_at_total: got %b expected 0", FrameCtrl); else passed++;
    endtask

    task automatic test_latency();
        bus_wr(1'b0, 1'b0, 16'h002C);
        clear_mon();
        @(posedge CLK);
        #3;
        I80_CS = 1'b0;
        I80_RS = 1'b1;
        I80_D  = 16'h5A5A;
        I80_WR = 1'b0;
        repeat (4) @(posedge CLK);
        #4 I80_WR = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        total++; if (FIFO_WE !== 1'b0) $display("FAIL lat_e1: got %b expected 0", FIFO_WE); else passed++;
        @(posedge CLK);
        @(negedge CLK);
        total++; if ({FIFO_WE, FIFO_WData} !== {1'b1, 16'h5A5A}) $display("FAIL lat_e2: got %b/%h expected 1/5a5a", FIFO_WE, FIFO_WData); else passed++;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (FIFO_WE !== 1'b0) $display("FAIL lat_e3: got %b expected 0", FIFO_WE); else passed++;
        @(posedge CLK);
        #3 I80_CS = 1'b1;
    endtask

    task automatic test_resume();
        bus_wr(1'b0, 1'b0, 16'h002C);
        clear_mon();
        for (int i = 0; i < 3; i++) bus_wr(1'b0, 1'b1, 16'h1000 + 16'(i));
        bus_wr(1'b0, 1'b0, 16'h0000);
        total++; if (FrameCtrl !== 1'b0) $display("FAIL resume_pause_ctrl: got %b expected 0", FrameCtrl); else passed++;
        total++; if (dut.pix_cnt !== 19'd3) $display("FAIL resume_pause_cnt: got %0d expected 3", dut.pix_cnt); else passed++;
        bus_wr(1'b0, 1'b0, 16'h003C);
        total++; if (FrameCtrl !== 1'b1) $display("FAIL resume_ctrl: got %b expected 1", FrameCtrl); else passed++;
        for (int i = 3; i < 8; i++) bus_wr(1'b0, 1'b1, 16'h1000 + 16'(i));
        total++; if (we_cnt !== 8) $display("FAIL resume_we_count: got %0d expected 8", we_cnt); else passed++;
        total++; if (done_cnt !== 1 || lone_done !== 0) $display("FAIL resume_done: got %0d pulses (%0d without WE) expected 1 (0)", done_cnt, lone_done); else passed++;
        total++; if (words.size() == 8 && words[7] !== 16'h1007) $display("FAIL resume_last_word: got %h expected 1007", words[7]); else passed++;
        bus_wr(1'b0, 1'b1, 16'hDEAD);
        bus_wr(1'b0, 1'b1, 16'hBEEF);
        total++; if (we_cnt !== 8) $display("FAIL resume_after_done: got %0d expected 8", we_cnt); else passed++;
    endtask

    task automatic test_overflow();
        bus_wr(1'b0, 1'b0, 16'h002C);
        clear_mon();
        bus_wr(1'b0, 1'b1, 16'h1111);
        FIFO_Full = 1'b1;
        bus_wr(1'b0, 1'b1, 16'h2222);
        FIFO_Full = 1'b0;
        bus_wr(1'b0, 1'b1, 16'h3333);
        bus_wr(1'b0, 1'b1, 16'h4444);
        total++; if (we_cnt !== 3) $display("FAIL ovf_we_count: got %0d expected 3", we_cnt); else passed++;
        total++; if (words.size() == 3 && {words[0], words[1], words[2]} !== {16'h1111, 16'h3333, 16'h4444}) $display("FAIL ovf_words: got %h %h %h expected 1111 3333 4444", words[0], words[1], words[2]); else passed++;
        total++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", Overflow); else passed++;
        total++; if (dut.pix_cnt !== 19'd4) $display("FAIL ovf_pixcnt: got %0d expected 4", dut.pix_cnt); else passed++;
        bus_wr(1'b0, 1'b0, 16'h002C);
        total++; if (Overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", Overflow); else passed++;
    endtask

    task automatic test_ignored();
        clear_mon();
        bus_wr(1'b1, 1'b1, 16'h7777);
        total++; if (we_cnt !== 0 || dut.pix_cnt !== 19'd0) $display("FAIL cs_high_data: got %0d pushes cnt %0d expected 0 0", we_cnt, dut.pix_cnt); else passed++;
        bus_wr(1'b0, 1'b0, 16'h0001);
        bus_wr(1'b1, 1'b0, 16'h002C);
        total++; if (FrameCtrl !== 1'b0) $display("FAIL cs_high_cmd: got %b expected 0", FrameCtrl); else passed++;
        bus_wr(1'b0, 1'b1, 16'h8888);
        bus_wr(1'b0, 1'b1, 16'h9999);
        total++; if (we_cnt !== 0 || FrameCtrl !== 1'b0) $display("FAIL idle_data: got %0d pushes ctrl %b expected 0 0", we_cnt, FrameCtrl); else passed++;
    endtask

    task automatic test_swreset();
        bus_wr(1'b0, 1'b0, 16'h002C);
        for (int i = 0; i < 3; i++) bus_wr(1'b0, 1'b1, 16'h2000 + 16'(i));
        clear_mon();
        bus_wr(1'b0, 1'b0, 16'h0001);
        total++; if (FrameCtrl !== 1'b0 || dut.pix_cnt !== 19'd0) $display("FAIL swrst_state: got ctrl %b cnt %0d expected 0 0", FrameCtrl, dut.pix_cnt); else passed++;
        total++; if (done_cnt !== 0 || we_cnt !== 0) $display("FAIL swrst_pulses: got done %0d we %0d expected 0 0", done_cnt, we_cnt); else passed++;
        bus_wr(1'b0, 1'b0, 16'h003C);
        total++; if (FrameCtrl !== 1'b1 || dut.pix_cnt !== 19'd0) $display("FAIL swrst_resume: got ctrl %b cnt %0d expected 1 0", FrameCtrl, dut.pix_cnt); else passed++;
        bus_wr(1'b0, 1'b1, 16'hCAFE);
        total++; if (we_cnt !== 1 || dut.pix_cnt !== 19'd1) $display("FAIL swrst_push: got %0d pushes cnt %0d expected 1 1", we_cnt, dut.pix_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        bus_wr(1'b0, 1'b0, 16'h002C);
        FIFO_Full = 1'b1;
        bus_wr(1'b0, 1'b1, 16'h3456);
        FIFO_Full = 1'b0;
        bus_wr(1'b0, 1'b1, 16'h789A);
        total++; if ({FrameCtrl, Overflow} !== 2'b11 || FIFO_WData !== 16'h789A) $display("FAIL arst_pre: got %b %h expected 11 789a", {FrameCtrl, Overflow}, FIFO_WData); else passed++;
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        total++; if ({FIFO_WE, FrameCtrl, FrameDone, Overflow} !== 4'b0000 || FIFO_WData !== 16'h0) $display("FAIL arst_outputs: got %b %h expected 0000 0000", {FIFO_WE, FrameCtrl, FrameDone, Overflow}, FIFO_WData); else passed++;
        total++; if (dut.pix_cnt !== 19'd0) $display("FAIL arst_pixcnt: got %0d expected 0", dut.pix_cnt); else passed++;
        @(posedge CLK);
        #3 nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_latency();
        test_resume();
        test_overflow();
        test_ignored();
        test_swreset();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
